// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs with flush.
// The head is read straight out of registered storage; when empty it shows the last head.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] last_head_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_pop_s;
  logic             do_push_s;
  logic             not_empty_s;

  // Qualify push/pop against occupancy; a full queue accepts a push only alongside a pop.
  always_comb begin
    not_empty_s = (count_r != {(PTR_W+1){1'b0}});
    do_pop_s    = pop & not_empty_s & ~flush;
    do_push_s   = push & ~flush & ((count_r != FULL_CNT) | do_pop_s);
  end

  // Entry storage and the held copy of the most recent head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      last_head_r <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
      end
      if (not_empty_s) begin
        last_head_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Pointers and occupancy; flush wins over everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + {{PTR_W{1'b0}}, do_push_s} - {{PTR_W{1'b0}}, do_pop_s};
    end
  end

  assign head  = not_empty_s ? mem_r[rd_ptr_r] : last_head_r;
  assign count = count_r;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues the PC to imem, pairs returned words with their PC,
// queues them for decode and steers the PC register's sequential-next input.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int bitwidth = 32,
  parameter int QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bitwidth-1:0] pc,
  input  logic                branch_decision,
  output logic [bitwidth-1:0] pc_plus_4,
  output logic [bitwidth-1:0] imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [bitwidth-1:0] id_pc,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [bitwidth-1:0] id_pc_plus_4
);
  localparam int ENTRY_W = bitwidth + INSTR_W;
  localparam int CNT_W   = $clog2(QDEPTH) + 1;

  logic                pend_valid_r;
  logic [bitwidth-1:0] pend_pc_r;
  logic [CNT_W-1:0]    count_s;
  logic [CNT_W:0]      occ_s;
  logic [ENTRY_W-1:0]  head_s;
  logic                deq_s;
  logic                issue_s;
  logic                push_s;
  logic                pop_s;

  // Issue only if the in-flight word is guaranteed a free slot after this cycle's dequeue.
  always_comb begin
    deq_s   = id_valid & id_ready;
    occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, pend_valid_r} - {{CNT_W{1'b0}}, deq_s};
    issue_s = ~branch_decision & (occ_s < (CNT_W+1)'(QDEPTH));
    push_s  = pend_valid_r & ~branch_decision;
    pop_s   = deq_s & ~branch_decision;
  end

  // PC register has no enable, so a stall feeds the current PC back.
  always_comb begin
    if (issue_s) begin
      pc_plus_4 = pc + bitwidth'(32'd4);
    end else begin
      pc_plus_4 = pc;
    end
  end

  // Tracks the fetch whose word arrives from imem next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_pc_r    <= {bitwidth{1'b0}};
    end else begin
      pend_valid_r <= issue_s;
      if (issue_s) begin
        pend_pc_r <= pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (branch_decision),
    .push_data ({pend_pc_r, imem_rdata}),
    .head      (head_s),
    .count     (count_s)
  );

  assign imem_addr    = pc;
  assign id_valid     = (count_s != {CNT_W{1'b0}});
  assign id_pc        = head_s[ENTRY_W-1 -: bitwidth];
  assign id_instr     = head_s[INSTR_W-1:0];
  assign id_pc_plus_4 = id_pc + bitwidth'(32'd4);
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-level reference model that
// also plays the PC register and a synchronous instruction memory.
module tb_fetch_stage;
  localparam int QDEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        branch_decision = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc_plus_4;
  logic [31:0] imem_addr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus_4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state as seen after the last clock edge, and staged state for the next one.
  ent_t        m_q[$];
  ent_t        s_q[$];
  bit          m_pend, s_pend;
  logic [31:0] m_pend_pc, s_pend_pc, s_pc;

  fetch_stage #(.bitwidth(32), .QDEPTH(QDEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .branch_decision (branch_decision),
    .pc_plus_4       (pc_plus_4),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_pc_plus_4    (id_pc_plus_4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) imem_rdata <= imem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s_q.delete();
    s_pend    = 1'b0;
    s_pend_pc = 32'd0;
    s_pc      = 32'd0;
  endtask

  // One clock: commit staged model state, drive inputs, check, stage the next state.
  task automatic cycle(input bit rdy, input bit br, input logic [31:0] tgt);
    bit          vld, deq, iss;
    int          occ;
    logic [31:0] exp_p4;
    ent_t        e;
    @(negedge clk);
    m_q       = s_q;
    m_pend    = s_pend;
    m_pend_pc = s_pend_pc;
    pc        = s_pc;
    id_ready        = rdy;
    branch_decision = br;
    #1;
    vld    = (m_q.size() > 0);
    deq    = vld && rdy;
    occ    = m_q.size() + int'(m_pend) - int'(deq);
    iss    = !br && (occ < QDEPTH);
    exp_p4 = iss ? pc + 32'd4 : pc;
    check("id_valid", {31'd0, id_valid}, {31'd0, vld});
    check("pc_plus_4", pc_plus_4, exp_p4);
    check("imem_addr", imem_addr, pc);
    if (vld) begin
      check("id_pc", id_pc, m_q[0].pc);
      check("id_instr", id_instr, m_q[0].instr);
      check("id_pc_plus_4", id_pc_plus_4, m_q[0].pc + 32'd4);
    end
    s_q = m_q;
    if (br) begin
      s_q.delete();
      s_pend = 1'b0;
      s_pc   = tgt;
    end else begin
      if (deq) void'(s_q.pop_front());
      if (m_pend) begin
        e.pc    = m_pend_pc;
        e.instr = imem_word(m_pend_pc);
        s_q.push_back(e);
      end
      s_pend = iss;
      if (iss) s_pend_pc = pc;
      s_pc = exp_p4;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, "_id_pc"}, id_pc, 32'd0);
    check({tag, "_id_instr"}, id_instr, 32'd0);
    check({tag, "_id_pc_plus_4"}, id_pc_plus_4, 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check_reset_outputs("reset");
    check("reset_pc_plus_4", pc_plus_4, 32'd4);
    @(posedge clk);
    #2 rst = 1'b1;

    // Straight-line fetch, then a full stall and release.
    repeat (8) cycle(1'b1, 1'b0, 32'd0);
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 32'd0);

    // Redirect while the queue is full and stalled.
    repeat (5) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0000_0100);
    repeat (5) cycle(1'b1, 1'b0, 32'd0);

    // Redirect coincident with a dequeue from a full queue.
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    repeat (5) cycle(1'b1, 1'b0, 32'd0);

    // Address wrap at the top of the PC space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (7) cycle(1'b1, 1'b0, 32'd0);

    repeat (300) cycle($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
                       $urandom & 32'hFFFF_FFFC);

    // Asynchronous reset with entries queued.
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    pc = 32'd0;
    branch_decision = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) cycle(1'b1, 1'b0, 32'd0);

    repeat (200) cycle($urandom_range(0, 9) < 6, $urandom_range(0, 14) == 0,
                       $urandom & 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
